// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - memory-mapped 4-digit seven-segment scan controller
module seg7_scan_driver #(
    parameter int          CLK_DIV    = 100000,
    parameter logic [31:0] ADDR_VALUE = 32'h4000_0014,
    parameter logic [31:0] ADDR_CTRL  = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [11:0] leds
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [15:0]   value;
    logic [7:0]    ctrl;
    logic [DW-1:0] div_cnt;
    logic [1:0]    idx;

    logic          wr_value;
    logic          wr_ctrl;
    logic          scan_en;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg;
    logic [11:0]   leds_next;
    logic          unused_wdata;

    assign wr_value     = MemWrite && (Address == ADDR_VALUE);
    assign wr_ctrl      = MemWrite && (Address == ADDR_CTRL);
    assign unused_wdata = ^Write_data[31:16];

    // A ctrl write that clears enable wins over a rollover on the same edge.
    assign scan_en = ctrl[0] && !(wr_ctrl && !Write_data[0]);

    always_comb begin
        nibble = value[3:0];
        blank  = 1'b0;
        case (idx)
            2'd1: begin nibble = value[7:4];   blank = (value[15:4]  == 12'h0); end
            2'd2: begin nibble = value[11:8];  blank = (value[15:8]  == 8'h0);  end
            2'd3: begin nibble = value[15:12]; blank = (value[15:12] == 4'h0);  end
            default: begin nibble = value[3:0]; blank = 1'b0; end
        endcase
        blank = blank && ctrl[1];
    end

    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    always_comb begin
        leds_next = 12'hF80;
        if (ctrl[0]) begin
            leds_next[11:8] = ~(4'b0001 << idx);
            leds_next[7]    = ~ctrl[4 + 32'(idx)];
            leds_next[6:0]  = blank ? 7'h00 : seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value   <= 16'h0;
            ctrl    <= 8'h0;
            div_cnt <= '0;
            idx     <= 2'd0;
            leds    <= 12'hF80;
        end else begin
            leds <= leds_next;
            if (wr_value) value <= Write_data[15:0];
            if (wr_ctrl)  ctrl  <= Write_data[7:0];
            if (!scan_en) begin
                div_cnt <= '0;
                idx     <= 2'd0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        Read_data = 32'h0;
        if (MemRead && (Address == ADDR_VALUE)) Read_data = {16'h0, value};
        else if (MemRead && (Address == ADDR_CTRL)) Read_data = {22'h0, idx, ctrl};
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int          CD     = 4;
    localparam logic [31:0] A_VAL  = 32'h4000_0014;
    localparam logic [31:0] A_CTRL = 32'h4000_0018;
    localparam logic [31:0] A_NONE = 32'h4000_001C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] Write_data = 32'h0;
    logic [31:0] Read_data;
    logic [11:0] leds;

    seg7_scan_driver #(.CLK_DIV(CD), .ADDR_VALUE(A_VAL), .ADDR_CTRL(A_CTRL)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data), .leds(leds)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0]  hex_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] m_value = 16'h0;
    logic [7:0]  m_ctrl  = 8'h0;
    int          m_phase = 0;
    logic [11:0] m_leds  = 12'hF80;

    function automatic int m_idx();
        return (m_phase / CD) % 4;
    endfunction

    function automatic logic [11:0] enc(int d, logic [15:0] v, logic [7:0] c);
        logic [15:0] upper;
        logic [3:0]  anode;
        logic [6:0]  s;
        upper = v >> (4 * d);
        anode = ~(4'b0001 << d);
        s = hex_seg[upper[3:0]];
        if (c[1] && d > 0 && upper == 16'h0) s = 7'h00;
        return {anode, ~c[4 + d], s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] exp_rd;
        logic        en;
        @(negedge clk);
        reset = rst; MemRead = rd; MemWrite = wr; Address = addr; Write_data = data;
        #1;
        exp_rd = 32'h0;
        if (rd && addr == A_VAL)  exp_rd = {16'h0, m_value};
        if (rd && addr == A_CTRL) exp_rd = {22'h0, 2'(m_idx()), m_ctrl};
        check("read_data", Read_data, exp_rd);
        @(posedge clk);
        if (rst) begin
            m_value = 16'h0; m_ctrl = 8'h0; m_phase = 0; m_leds = 12'hF80;
        end else begin
            m_leds = m_ctrl[0] ? enc(m_idx(), m_value, m_ctrl) : 12'hF80;
            en = m_ctrl[0] && !(wr && addr == A_CTRL && !data[0]);
            m_phase = en ? (m_phase + 1) % (4 * CD) : 0;
            if (wr && addr == A_VAL)  m_value = data[15:0];
            if (wr && addr == A_CTRL) m_ctrl  = data[7:0];
        end
        #1;
        check("leds", {20'h0, leds}, {20'h0, m_leds});
    endtask

    task automatic idle_read(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, (i % 2) ? A_CTRL : A_VAL, 32'h0);
    endtask

    task automatic wait_phase(input int last_in_digit, input int digit);
        for (int i = 0; i < 4 * CD; i++) begin
            if ((m_phase % CD) == last_in_digit && (digit < 0 || m_idx() == digit)) break;
            step(1'b0, 1'b1, 1'b0, A_CTRL, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] data;
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, A_VAL, 32'h0);
        idle_read(20);

        step(1'b0, 1'b0, 1'b1, A_VAL, 32'h0000_1234);
        step(1'b0, 1'b1, 1'b1, A_CTRL, 32'h0000_0001);
        idle_read(40);

        step(1'b0, 1'b0, 1'b1, A_VAL, 32'hFFFF_00A0);
        step(1'b0, 1'b0, 1'b1, A_CTRL, 32'h0000_0003);
        idle_read(20);

        step(1'b0, 1'b0, 1'b1, A_CTRL, 32'h0000_0021);
        idle_read(20);

        wait_phase(CD - 1, -1);
        step(1'b0, 1'b1, 1'b1, A_VAL, 32'h0000_BEEF);
        idle_read(6);
        step(1'b0, 1'b1, 1'b1, A_NONE, 32'h0000_0000);
        idle_read(4);

        wait_phase(CD - 1, 1);
        step(1'b0, 1'b1, 1'b1, A_CTRL, 32'h0000_0020);
        idle_read(6);
        step(1'b0, 1'b0, 1'b1, A_CTRL, 32'h0000_00F1);
        idle_read(10);

        wait_phase(1, 2);
        step(1'b1, 1'b1, 1'b1, A_VAL, 32'h0000_5555);
        step(1'b0, 1'b1, 1'b0, A_CTRL, 32'h0);
        idle_read(4);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: addr = A_VAL;
                1: addr = A_CTRL;
                2: addr = A_NONE;
                default: addr = $urandom;
            endcase
            data = $urandom >> $urandom_range(0, 28);
            if (addr == A_CTRL && $urandom_range(0, 3) != 0) data[0] = 1'b1;
            step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, addr, data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
